// File: rtl/writeback.sv
// writeback: final LC-3 datapath stage. Selects the commit value, writes the
// 8x16 register file, maintains the N/Z/P condition codes, serves the two
// decode read ports with write-through bypass, and registers a commit record
// for forwarding/observation.
module writeback #(
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_writeback,
  input  logic [1:0]  W_control,
  input  logic [15:0] aluout,
  input  logic [15:0] memout,
  input  logic [15:0] pcout,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] vsr1,
  output logic [15:0] vsr2,
  output logic [2:0]  psr,
  output logic        wb_valid,
  output logic [2:0]  wb_dr,
  output logic [15:0] wb_data
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_PC   = 2'b10,
    SEL_RSVD = 2'b11
  } wsel_e;

  wsel_e       wsel;
  logic        commit;
  logic [15:0] wr_data;
  logic [2:0]  psr_d;

  logic [15:0] regs_q [8];
  logic [2:0]  psr_q;
  logic        wb_valid_q;
  logic [2:0]  wb_dr_q;
  logic [15:0] wb_data_q;

  assign wsel = wsel_e'(W_control);

  // Commit qualification and write-data selection. Holding rst in the
  // qualifier keeps the bypass from leaking stimulus while reset is asserted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    wr_data = aluout;
    commit  = 1'b0;
    unique case (wsel)
      SEL_ALU:  begin wr_data = aluout; commit = enable_writeback & rst; end
      SEL_MEM:  begin wr_data = memout; commit = enable_writeback & rst; end
      SEL_PC:   begin wr_data = pcout;  commit = enable_writeback & rst; end
      SEL_RSVD: begin wr_data = aluout; commit = 1'b0;                  end
    endcase
  end

  // Next condition codes: only ALU and load commits touch psr; linkage
  // commits and non-commits hold. Exactly one of N/Z/P is ever set.
  always_comb begin
    psr_d = psr_q;
    if (commit && (wsel == SEL_ALU || wsel == SEL_MEM)) begin
      if (wr_data == 16'h0000)  psr_d = 3'b010;
      else if (wr_data[15])     psr_d = 3'b100;
      else                      psr_d = 3'b001;
    end
  end

  // Register file write; only R[dr] changes on a commit.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the array is small and architecturally visible, so it is cleared
    // by the async reset like any other register rather than left to a RAM.
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else if (commit) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      regs_q[dr] <= wr_data;
    end
  end

  // Condition-code register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) psr_q <= NZP_RESET;
    else      psr_q <= psr_d;
  end

  // Commit record: valid pulses for one cycle per commit; dr/data hold the
  // most recent commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_dr_q    <= 3'b000;
      wb_data_q  <= 16'h0000;
    end else begin
      wb_valid_q <= commit;
      if (commit) begin
        wb_dr_q   <= dr;
        wb_data_q <= wr_data;
      end
    end
  end

  // Read ports with independent write-through bypass.
  always_comb begin
    vsr1 = regs_q[sr1];
    vsr2 = regs_q[sr2];
    if (commit && sr1 == dr) vsr1 = wr_data;
    if (commit && sr2 == dr) vsr2 = wr_data;
  end

  assign psr      = psr_q;
  assign wb_valid = wb_valid_q;
  assign wb_dr    = wb_dr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: doc/writeback.md
# writeback

Final stage of the LC-3 datapath, directly downstream of `memory_access`. It selects the value to commit from the ALU result, the memory stage's `memout`, or the linkage PC, and writes it into the 8×16 general-purpose register file. It updates the N/Z/P condition codes and serves the two register read ports used by decode. A registered commit record (`wb_valid`, `wb_dr`, `wb_data`) is provided for forwarding and bench observation.

## Interface
- `NZP_RESET`, default 3'b010, value loaded into `psr` on reset (Z set).

- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable_writeback`  input  1  commit strobe; one instruction committed per cycle it is high.
- `W_control`  input  2  source select: 00 `aluout`, 01 `memout`, 10 `pcout`, 11 reserved (no commit).
- `aluout`  input  16  execute-stage result (ADD/AND/NOT/LEA).
- `memout`  input  16  load data from `memory_access`.
- `pcout`  input  16  return address for JSR/JSRR/TRAP.
- `dr`  input  3  destination register index.
- `sr1`, `sr2`  input  3 each  read addresses from decode.
- `vsr1`, `vsr2`  output  16 each  read data.
- `psr`  output  3  condition codes {N,Z,P}.
- `wb_valid`  output  1  registered; high the cycle after a commit.
- `wb_dr`  output  3  registered destination of last commit.
- `wb_data`  output  16  registered value of last commit.

## Operation
- Commit occurs when `enable_writeback`=1 and `W_control`≠11.
- Write data: `aluout`, `memout` or `pcout` per `W_control`. It is written to `R[dr]`. No other register changes.
- `W_control`=11 with `enable_writeback`=1 is treated as no commit:
  - no register write;
  - no `psr` change;
  - `wb_valid`=0.
- Condition codes update on commits with `W_control`=00 or 01:
  - N = data[15];
  - Z = (data==0);
  - P = !data[15] && data≠0.
  - Exactly one bit is set at all times.
- Commits with `W_control`=10 (linkage to R7 by convention, but `dr` is honoured) write the register and leave `psr` unchanged.
- Read ports are combinational with write-through bypass. If a commit is active this cycle and `srN`==`dr`, `vsrN` returns the write data; otherwise it returns `R[srN]`. Both ports bypass independently; `sr1`==`sr2`==`dr` returns the write data on both.
- No arithmetic beyond zero/sign detection; all data is 16-bit, no width extension.

## Timing
- Register and `psr` update on the rising edge where the commit is sampled; the new value is visible via the array the next cycle and via bypass in the same cycle.
- `wb_valid`, `wb_dr`, `wb_data` are registered, with 1-cycle latency from the commit edge. `wb_valid` deasserts the cycle after a non-commit.
- Back-to-back commits every cycle are supported. A commit to the same `dr` on consecutive cycles is last-writer-wins; reads in the second cycle bypass the second value.
- Reset (async, `rst`=0) takes effect immediately regardless of `clk`:
  - R0–R7 = 16'h0000;
  - `psr` = `NZP_RESET`;
  - `wb_valid` = 0, `wb_dr` = 3'b000, `wb_data` = 16'h0000.
- Reset asserted mid-commit: the commit is discarded and reset values win.
- While `rst`=0, `vsr1`/`vsr2` read 16'h0000 (array is cleared and no commit is accepted).
- Release of `rst` is synchronous to the design. The first commit is accepted on the first rising edge with `rst`=1.

## Test plan
- Reset check: pulse `rst` low between clock edges. Required: all outputs go to reset values immediately; `psr`=010; reads of R0–R7 = 0000.
- ALU commit: `W_control`=00, `aluout`=16'h8001, `dr`=3, `enable_writeback`=1 for one cycle.
  - Required: R3=8001, `psr`=100.
  - Next cycle: `wb_valid`=1, `wb_dr`=3, `wb_data`=8001.
  - Following cycle: `wb_valid`=0.
- Load and link:
  - Commit `memout`=0000 to R1. Required: `psr`=010.
  - Then commit `pcout`=3005 to R7. Required: R7=3005, `psr` stays 010.
- Bypass: `sr1`=`sr2`=`dr`=5, `aluout`=0042, commit active. Required: same-cycle `vsr1`=`vsr2`=0042 while R5 still holds its old value; next cycle `psr`=001.
- Reserved select: `W_control`=11, `enable_writeback`=1, `dr`=2, `aluout`=FFFF. Required: R2 unchanged, `psr` unchanged, `wb_valid` stays 0.
- Reset mid-stream: back-to-back commits to R4 (1111, then 2222), with `rst` driven low between the two edges. Required: R4=0000, `psr`=010, `wb_valid`=0; the 2222 commit is never applied.
